// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared MIPS pipeline types plus the pipeline controller state
//               encoding and a register-match helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTING = 2'd1,
    HALTED  = 2'd2
  } pctl_state_t;

  // A source operand depends on a producer only if it is really read and the
  // producer targets a register other than $0.
  function automatic logic src_match(input logic used, input regbits_t src,
                                     input regbits_t dst);
    return used && (dst != '0) && (src == dst);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_controller_hazard_detect.sv
// ============================================================================
// Module      : hazard_detect
// Description : Combinational RAW comparator between the instruction in ID and
//               older producers. Macro FORWARDING_EN limits it to load-use.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     useRs_ID,
  input  logic     useRt_ID,
  input  regbits_t rs_ID,
  input  regbits_t rt_ID,
  input  logic     RegWr_EX,
  input  logic     memtoReg_EX,
  input  regbits_t wsel_EX,
  input  logic     RegWr_MEM,
  input  regbits_t wsel_MEM,
  output logic     raw_stall
);

  logic w_ex_match;
  logic w_mem_match;

  assign w_ex_match  = src_match(useRs_ID, rs_ID, wsel_EX)  | src_match(useRt_ID, rt_ID, wsel_EX);
  assign w_mem_match = src_match(useRs_ID, rs_ID, wsel_MEM) | src_match(useRt_ID, rt_ID, wsel_MEM);

`ifdef FORWARDING_EN
  // Forwarding covers ALU results; only a load in EX is still too late.
  logic w_unused_mem;
  assign w_unused_mem = RegWr_MEM & w_mem_match;
  assign raw_stall    = RegWr_EX & memtoReg_EX & w_ex_match;
`else
  // Without forwarding, wait until the producer has reached WB.
  logic w_unused_ld;
  assign w_unused_ld = memtoReg_EX;
  assign raw_stall   = (RegWr_EX & w_ex_match) | (RegWr_MEM & w_mem_match);
`endif

endmodule

`default_nettype wire

// File: rtl/pipeline_controller.sv
// ============================================================================
// Module      : pipeline_controller
// Description : Hazard/sequencing controller for the 5-stage MIPS pipeline.
//               Optional macro FORWARDING_EN (see hazard_detect).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_controller
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dREN_MEM,
  input  logic             dWEN_MEM,
  input  regbits_t         rs_ID,
  input  regbits_t         rt_ID,
  input  logic             useRs_ID,
  input  logic             useRt_ID,
  input  logic             RegWr_EX,
  input  logic             memtoReg_EX,
  input  regbits_t         wsel_EX,
  input  logic             RegWr_MEM,
  input  regbits_t         wsel_MEM,
  input  logic             brTaken_EX,
  input  logic             jump_ID,
  input  logic             halt_EX,
  input  logic             halt_WB,
  output logic             pcEn,
  output logic             enIFID,
  output logic             enIDEX,
  output logic             enEXMEM,
  output logic             enMEMWB,
  output logic             flIFID,
  output logic             flIDEX,
  output logic             flEXMEM,
  output logic             halt,
  output logic [CNT_W-1:0] stallCnt
);

  pctl_state_t      r_state;
  pctl_state_t      w_next_state;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_raw_stall;
  logic             w_dmem_wait;

  assign w_dmem_wait = (dREN_MEM | dWEN_MEM) & ~dhit;

  hazard_detect u_hazard_detect (
    .useRs_ID    (useRs_ID),
    .useRt_ID    (useRt_ID),
    .rs_ID       (rs_ID),
    .rt_ID       (rt_ID),
    .RegWr_EX    (RegWr_EX),
    .memtoReg_EX (memtoReg_EX),
    .wsel_EX     (wsel_EX),
    .RegWr_MEM   (RegWr_MEM),
    .wsel_MEM    (wsel_MEM),
    .raw_stall   (w_raw_stall)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Flush dominates enable, so enables stay high on flushed latches.
  always_comb begin
    w_next_state = r_state;
    pcEn         = 1'b1;
    enIFID       = 1'b1;
    enIDEX       = 1'b1;
    enEXMEM      = 1'b1;
    enMEMWB      = 1'b1;
    flIFID       = 1'b0;
    flIDEX       = 1'b0;
    flEXMEM      = 1'b0;
    halt         = 1'b0;
    case (r_state)
      RUN: begin
        if (halt_EX) begin
          w_next_state = HALTING;
        end
        if (w_dmem_wait) begin
          pcEn    = 1'b0;
          enIFID  = 1'b0;
          enIDEX  = 1'b0;
          enEXMEM = 1'b0;
          enMEMWB = 1'b0;
        end else if (brTaken_EX) begin
          flIFID = 1'b1;
          flIDEX = 1'b1;
        end else if (w_raw_stall) begin
          pcEn   = 1'b0;
          enIFID = 1'b0;
          flIDEX = 1'b1;
        end else if (!ihit) begin
          pcEn   = 1'b0;
          flIFID = 1'b1;
        end else if (jump_ID) begin
          flIFID = 1'b1;
        end
      end
      HALTING: begin
        if (halt_WB) begin
          w_next_state = HALTED;
        end
        pcEn   = 1'b0;
        flIFID = 1'b1;
        flIDEX = 1'b1;
        if (w_dmem_wait) begin
          enIFID  = 1'b0;
          enIDEX  = 1'b0;
          enEXMEM = 1'b0;
          enMEMWB = 1'b0;
        end
      end
      HALTED: begin
        halt    = 1'b1;
        pcEn    = 1'b0;
        enIFID  = 1'b0;
        enIDEX  = 1'b0;
        enEXMEM = 1'b0;
        enMEMWB = 1'b0;
      end
      default: begin
        w_next_state = RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt <= '0;
    end else if ((r_state == RUN) && !pcEn && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stallCnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_controller.sv
// ============================================================================
// Module      : tb_pipeline_controller
// Description : Directed bench for pipeline_controller with a reference model
//               checked every cycle plus literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_controller;

  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // {pcEn, enIFID, enIDEX, enEXMEM, enMEMWB, flIFID, flIDEX, flEXMEM, halt}
  localparam logic [8:0] V_FREEZE   = 9'b0_0000_000_0;
  localparam logic [8:0] V_BRANCH   = 9'b1_1111_110_0;
  localparam logic [8:0] V_LOADUSE  = 9'b0_0111_010_0;
  localparam logic [8:0] V_NOFETCH  = 9'b0_1111_100_0;
  localparam logic [8:0] V_JUMP     = 9'b1_1111_100_0;
  localparam logic [8:0] V_NORMAL   = 9'b1_1111_000_0;
  localparam logic [8:0] V_HALTING  = 9'b0_1111_110_0;
  localparam logic [8:0] V_HALT_FRZ = 9'b0_0000_110_0;
  localparam logic [8:0] V_HALTED   = 9'b0_0000_000_1;

`ifdef FORWARDING_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic CLK, nRST;
  logic ihit, dhit, dREN_MEM, dWEN_MEM;
  logic [4:0] rs_ID, rt_ID, wsel_EX, wsel_MEM;
  logic useRs_ID, useRt_ID, RegWr_EX, memtoReg_EX, RegWr_MEM;
  logic brTaken_EX, jump_ID, halt_EX, halt_WB;
  logic pcEn, enIFID, enIDEX, enEXMEM, enMEMWB, flIFID, flIDEX, flEXMEM, halt;
  logic [CNT_W-1:0] stallCnt;

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;
  int m_mode;  // 0 run, 1 halting, 2 halted
  int m_cnt;

  pipeline_controller #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dREN_MEM(dREN_MEM), .dWEN_MEM(dWEN_MEM),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .useRs_ID(useRs_ID), .useRt_ID(useRt_ID),
    .RegWr_EX(RegWr_EX), .memtoReg_EX(memtoReg_EX), .wsel_EX(wsel_EX),
    .RegWr_MEM(RegWr_MEM), .wsel_MEM(wsel_MEM),
    .brTaken_EX(brTaken_EX), .jump_ID(jump_ID), .halt_EX(halt_EX), .halt_WB(halt_WB),
    .pcEn(pcEn), .enIFID(enIFID), .enIDEX(enIDEX), .enEXMEM(enEXMEM), .enMEMWB(enMEMWB),
    .flIFID(flIFID), .flIDEX(flIDEX), .flEXMEM(flEXMEM), .halt(halt), .stallCnt(stallCnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic bit model_hazard();
    bit       ok  [2];
    bit [4:0] dst [2];
    ok[0]  = (FWD != 0) ? (RegWr_EX && memtoReg_EX) : RegWr_EX;
    ok[1]  = (FWD != 0) ? 1'b0 : RegWr_MEM;
    dst[0] = wsel_EX;
    dst[1] = wsel_MEM;
    for (int i = 0; i < 2; i++) begin
      if (ok[i] && dst[i] != 5'd0 &&
          ((useRs_ID && rs_ID == dst[i]) || (useRt_ID && rt_ID == dst[i])))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [8:0] expect_vec(int mode);
    bit mem_wait;
    mem_wait = (dREN_MEM || dWEN_MEM) && !dhit;
    if (mode == 2) return V_HALTED;
    if (mode == 1) return mem_wait ? V_HALT_FRZ : V_HALTING;
    if (mem_wait)       return V_FREEZE;
    if (brTaken_EX)     return V_BRANCH;
    if (model_hazard()) return V_LOADUSE;
    if (!ihit)          return V_NOFETCH;
    if (jump_ID)        return V_JUMP;
    return V_NORMAL;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    logic [8:0] ev;
    if (!nRST) begin
      m_mode = 0;
      m_cnt  = 0;
    end else begin
      ev = expect_vec(m_mode);
      if (m_mode == 0 && ev[8] == 1'b0 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (m_mode == 0 && halt_EX) m_mode = 1;
      else if (m_mode == 1 && halt_WB) m_mode = 2;
    end
  end

  always @(negedge CLK) begin
    logic [8:0] ev, av;
    if (chk_on && nRST) begin
      ev = expect_vec(m_mode);
      av = {pcEn, enIFID, enIDEX, enEXMEM, enMEMWB, flIFID, flIDEX, flEXMEM, halt};
      total++;
      if (av !== ev) begin
        bad++;
        $display("FAIL model_outputs t=%0t got=%b want=%b", $time, av, ev);
      end
      total++;
      if (int'(stallCnt) != m_cnt) begin
        bad++;
        $display("FAIL model_stallCnt t=%0t got=%0d want=%0d", $time, stallCnt, m_cnt);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
    end
  endtask

  task automatic idle();
    ihit = 1; dhit = 0; dREN_MEM = 0; dWEN_MEM = 0;
    rs_ID = 0; rt_ID = 0; useRs_ID = 0; useRt_ID = 0;
    RegWr_EX = 0; memtoReg_EX = 0; wsel_EX = 0; RegWr_MEM = 0; wsel_MEM = 0;
    brTaken_EX = 0; jump_ID = 0; halt_EX = 0; halt_WB = 0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    nRST = 0;
    #2;
    check("rst_stallCnt", int'(stallCnt), 0);
    check("rst_halt", int'(halt), 0);
    next_cycle();
    idle();
    nRST = 1;
    chk_on = 1;
  endtask

  initial begin
    nRST = 1;
    idle();
    do_reset();
    #2;
    check("rst_pcEn", int'(pcEn), 1);

    // load r2 followed by add r3,r2,r1
    next_cycle(); idle();
    RegWr_EX = 1; memtoReg_EX = 1; wsel_EX = 5'd2;
    useRs_ID = 1; rs_ID = 5'd2; useRt_ID = 1; rt_ID = 5'd1;
    #2;
    check("lu_pcEn", int'(pcEn), 0);
    check("lu_enIFID", int'(enIFID), 0);
    check("lu_flIDEX", int'(flIDEX), 1);
    next_cycle(); idle();
    dREN_MEM = 1; dhit = 1; RegWr_MEM = 1; wsel_MEM = 5'd2;
    useRs_ID = 1; rs_ID = 5'd2; useRt_ID = 1; rt_ID = 5'd1;
    next_cycle(); idle();
    #2;
    check("lu_stallCnt", int'(stallCnt), (FWD != 0) ? 1 : 2);

    // same shape, destination $0
    do_reset();
    RegWr_EX = 1; memtoReg_EX = 1; wsel_EX = 5'd0;
    useRs_ID = 1; rs_ID = 5'd0;
    #2;
    check("r0_pcEn", int'(pcEn), 1);
    next_cycle(); idle();
    #2;
    check("r0_stallCnt", int'(stallCnt), 0);

    // dmem wait three cycles; last wait also lacks ihit
    do_reset();
    for (int i = 0; i < 3; i++) begin
      next_cycle(); idle();
      dREN_MEM = 1; dhit = 0; ihit = (i != 2);
      #2;
      check("dw_enMEMWB", int'(enMEMWB), 0);
    end
    next_cycle(); idle();
    dREN_MEM = 1; dhit = 1; ihit = 0;
    #2;
    check("dw_release_flIFID", int'(flIFID), 1);
    check("dw_stallCnt", int'(stallCnt), 3);
    next_cycle(); idle();
    #2;
    check("dw_normal_pcEn", int'(pcEn), 1);

    // branch taken with fetch pending, and priority corners
    do_reset();
    brTaken_EX = 1; ihit = 0;
    #2;
    check("br_pcEn", int'(pcEn), 1);
    check("br_flIDEX", int'(flIDEX), 1);
    next_cycle(); idle();
    brTaken_EX = 1; dWEN_MEM = 1;
    #2;
    check("br_frozen_pcEn", int'(pcEn), 0);
    next_cycle(); idle();
    jump_ID = 1;
    #2;
    check("jump_flIFID", int'(flIFID), 1);
    next_cycle(); idle();
    ihit = 0; RegWr_EX = 1; memtoReg_EX = 1; wsel_EX = 5'd7; useRt_ID = 1; rt_ID = 5'd7;
    #2;
    check("lu_over_ihit_flIFID", int'(flIFID), 0);

    // ALU producer addi r4 then sub r5,r4,r4
    do_reset();
    RegWr_EX = 1; wsel_EX = 5'd4; useRs_ID = 1; rs_ID = 5'd4; useRt_ID = 1; rt_ID = 5'd4;
    next_cycle(); idle();
    RegWr_MEM = 1; wsel_MEM = 5'd4; useRs_ID = 1; rs_ID = 5'd4; useRt_ID = 1; rt_ID = 5'd4;
    next_cycle(); idle();
    useRs_ID = 1; rs_ID = 5'd4;
    #2;
    check("alu_stallCnt", int'(stallCnt), (FWD != 0) ? 0 : 2);

    // counter saturation, then reset in the middle of a stall
    do_reset();
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      next_cycle(); idle(); ihit = 0;
    end
    #2;
    check("sat_stallCnt", int'(stallCnt), CNT_MAX);
    do_reset();

    // halt sequence
    halt_EX = 1;
    #2;
    check("h_run_pcEn", int'(pcEn), 1);
    next_cycle(); idle(); ihit = 0;
    #2;
    check("h_halting_flIFID", int'(flIFID), 1);
    check("h_halting_enEXMEM", int'(enEXMEM), 1);
    next_cycle(); idle(); halt_WB = 1;
    next_cycle(); idle();
    #2;
    check("h_halted_halt", int'(halt), 1);
    check("h_halted_enMEMWB", int'(enMEMWB), 0);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); idle(); ihit = 0; brTaken_EX = (i == 1);
    end
    #2;
    check("h_sticky_halt", int'(halt), 1);
    check("h_no_count", int'(stallCnt), 0);

    // halt while a data access stalls
    do_reset();
    halt_EX = 1;
    next_cycle(); idle(); dREN_MEM = 1;
    #2;
    check("hf_enEXMEM", int'(enEXMEM), 0);
    check("hf_flIDEX", int'(flIDEX), 1);
    next_cycle(); idle(); halt_WB = 1;
    next_cycle(); idle();
    #2;
    check("hf_halt", int'(halt), 1);
    do_reset();
    next_cycle(); idle();

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
